lr35902_oam_dma: RTL and testbench
==================================

# lr35902_oam_dma

OAM DMA controller for the LR35902 system. It owns the FF46 register and, once armed, copies 160 bytes from `{src_page, 8'h00}` into OAM (FE00–FE9F), one byte per 4 clocks. It drives a request on the external/system bus and the OAM write port, and flags `dma_active` so the CPU-side bus mux and the PPU OAM mux can block or steal access. It runs on the same dot clock as the PPU (456 clocks per line).

## Interface
Parameters:
- `XFER_LEN`, 160: bytes per transfer.
- `START_DELAY`, 4: clocks from write commit to the first source read.

Ports:
- `clk` input 1: system/dot clock; all logic on posedge.
- `reset` input 1: synchronous, active-high.
- `reg_din` input 8: CPU write data for FF46.
- `reg_write` input 1: CPU write strobe for FF46 (chip-select already decoded).
- `reg_dout` output 8: FF46 readback, registered.
- `ext_adr` output 16: source address to the system bus.
- `ext_read` output 1: source read strobe, one clock.
- `ext_data` input 8: source data, valid the clock after `ext_read`.
- `oam_adr` output 8: OAM byte index 0..159.
- `oam_dout` output 8: byte to write.
- `oam_write` output 1: OAM write strobe, one clock.
- `dma_active` output 1: a transfer owns the bus/OAM.

## Operation
- Write commit:
  - A write commits on the clock where `r_reg_write && !reg_write`, i.e. the falling edge of the strobe.
  - On commit: `src_page <= reg_din`, `reg_dout <= reg_din`, and a pending start is armed with `delay <= START_DELAY-1`.
- Effective source high byte:
  - `reg_din` 00–DF is used as is.
  - `reg_din` E0–FF maps to value minus 8'h20 (echo RAM).
  - `ext_adr = {eff_page, idx}`.
- States:
  - `IDLE`: `dma_active=0`.
  - `XFER`: 4-phase loop per byte, `phase` 0..3:
    - phase 0: `ext_read=1`, `ext_adr={eff_page, idx}`.
    - phase 1: latch `ext_data` into `byte_buf`.
    - phase 2: `oam_write=1`, `oam_adr=idx`, `oam_dout=byte_buf`.
    - phase 3: `idx<=idx+1`. If `idx==XFER_LEN-1`, go to `IDLE`.
- Start:
  - The pending counter decrements each clock.
  - When it reaches 0 with a start pending: `idx<=0`, `phase<=0`, `page<=new eff_page`, state `XFER`, pending cleared.
  - `dma_active` rises on that same clock.
- Restart while in `XFER`:
  - The old transfer keeps running unchanged, same page, during the delay.
  - It is replaced at delay expiry; the new transfer starts at idx 0.
  - `dma_active` stays 1 throughout, with no gap.
- Write during the start delay: re-arms the delay from `START_DELAY-1` and replaces the pending page; only the last write takes effect.
- Widths:
  - `idx` is 8 bits and never exceeds 159.
  - `phase` is 2 bits and wraps 3→0.
  - `delay` is 2 bits.
- Outputs when not driving: `ext_adr=0`, `oam_adr=0`, `oam_dout=0`, strobes 0.

## Timing
- Reset values:
  - `reg_dout=8'h00`, `src_page=0`, state `IDLE`, no pending.
  - All outputs 0.
- Reset mid-transfer aborts immediately. OAM keeps whatever was already written.
- Latency from commit clock C:
  - First `ext_read` at C+START_DELAY.
  - First `oam_write` at C+START_DELAY+2.
  - Last `oam_write` (idx 159) at C+START_DELAY+158*4+... = C+START_DELAY+4*159+2.
  - `dma_active` falls at C+START_DELAY+640.
- Transfer length: exactly 640 clocks of `dma_active` for 160 bytes.
- Strobes:
  - `ext_read` and `oam_write` are never both asserted.
  - Each is high exactly 160 times per uninterrupted transfer.
- `reg_dout` updates on the commit clock. It is readable at any time, including during `XFER`.
- Simultaneous reset and commit: reset wins.

## Test plan
- Write 8'hC1, then release the strobe at clock C → `ext_read` at C+4 with `ext_adr=16'hC100`. `oam_write` at C+6 with `oam_adr=0` and `oam_dout` = byte from C100. 160 writes total. `dma_active` is high for exactly 640 clocks.
- Write 8'hFE → `ext_adr` runs 16'hDE00..16'hDE9F (echo mapping). Write 8'hDF → 16'hDF00..16'hDF9F.
- Write 8'h80, then write 8'hC0 at byte 50 → bytes 50..~51 still come from page 80. At delay expiry idx resets to 0 and the page becomes C0. `dma_active` never drops. 160 further writes follow.
- Two writes (8'h80 then 8'h90) 2 clocks apart, both before the start → a single transfer from page 90. The first `ext_read` comes START_DELAY after the second commit.
- Assert `reset` at byte 100 → on the next clock `dma_active=0`, all strobes 0, `reg_dout=0`. No further `oam_write`.
- Read `reg_dout` after writing 8'h5A → 8'h5A, both during and after the transfer.

Source files
------------

// File: rtl/lr35902_oam_dma.sv
// OAM DMA controller: owns FF46 and copies XFER_LEN bytes from a source page into OAM,
// one byte every 4 clocks, after a START_DELAY lag from the falling edge of the write strobe.
module lr35902_oam_dma #(
  parameter int XFER_LEN    = 160,
  parameter int START_DELAY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  reg_din,
  input  logic        reg_write,
  output logic [7:0]  reg_dout,
  output logic [15:0] ext_adr,
  output logic        ext_read,
  input  logic [7:0]  ext_data,
  output logic [7:0]  oam_adr,
  output logic [7:0]  oam_dout,
  output logic        oam_write,
  output logic        dma_active
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state, state_nx;
  logic        r_reg_write;
  logic        pending;
  logic [1:0]  delay;
  logic [7:0]  src_page;
  logic [7:0]  eff_src;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [1:0]  phase;
  logic [7:0]  byte_buf;
  logic        commit;
  logic        start;
  logic        last;

  assign commit  = r_reg_write && !reg_write;
  // A commit landing on the expiry clock re-arms instead of starting: the last write wins.
  assign start   = pending && (delay == 2'd0) && !commit;
  assign last    = (phase == 2'd3) && (idx == 8'(XFER_LEN - 1));
  // E0-FF alias onto C0-DF (echo RAM)
  assign eff_src = (src_page >= 8'hE0) ? src_page - 8'h20 : src_page;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    ext_read   = 1'b0;
    ext_adr    = 16'h0000;
    oam_write  = 1'b0;
    oam_adr    = 8'h00;
    oam_dout   = 8'h00;
    dma_active = (state == XFER);
    if (start)                        state_nx = XFER;
    else if (state == XFER && last)   state_nx = IDLE;
    if (state == XFER) begin
      case (phase)
        2'd0: begin
          ext_read = 1'b1;
          ext_adr  = {page, idx};
        end
        2'd2: begin
          oam_write = 1'b1;
          oam_adr   = idx;
          oam_dout  = byte_buf;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_write <= 1'b0;
      pending     <= 1'b0;
      delay       <= 2'd0;
      src_page    <= 8'h00;
      reg_dout    <= 8'h00;
      page        <= 8'h00;
      idx         <= 8'h00;
      phase       <= 2'd0;
      byte_buf    <= 8'h00;
    end else begin
      r_reg_write <= reg_write;
      if (commit) begin
        src_page <= reg_din;
        reg_dout <= reg_din;
        pending  <= 1'b1;
        delay    <= 2'(START_DELAY - 1);
      end else if (pending) begin
        if (delay == 2'd0) pending <= 1'b0;
        else               delay   <= delay - 2'd1;
      end
      // A start also preempts a running transfer; the old one simply stops at this clock.
      if (start) begin
        idx   <= 8'h00;
        phase <= 2'd0;
        page  <= eff_src;
      end else if (state == XFER) begin
        phase <= phase + 2'd1;
        if (phase == 2'd1) byte_buf <= ext_data;
        if (phase == 2'd3) idx <= last ? 8'h00 : idx + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_lr35902_oam_dma.sv
// Bench for lr35902_oam_dma: random source memory, event capture on the negedge, and an
// expected event list built from the transfer timing rules (read at S+4i, write at S+4i+2).
module tb_lr35902_oam_dma;
  localparam int SD  = 4;
  localparam int LEN = 160;
  localparam int BIG = 32'h7fffffff;

  typedef struct {
    int          cyc;
    logic [15:0] adr;
    logic [7:0]  dat;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  reg_din;
  logic        reg_write;
  logic [7:0]  reg_dout;
  logic [15:0] ext_adr;
  logic        ext_read;
  logic [7:0]  ext_data;
  logic [7:0]  oam_adr;
  logic [7:0]  oam_dout;
  logic        oam_write;
  logic        dma_active;

  lr35902_oam_dma #(.XFER_LEN(LEN), .START_DELAY(SD)) dut (
    .clk(clk), .reset(reset), .reg_din(reg_din), .reg_write(reg_write),
    .reg_dout(reg_dout), .ext_adr(ext_adr), .ext_read(ext_read), .ext_data(ext_data),
    .oam_adr(oam_adr), .oam_dout(oam_dout), .oam_write(oam_write), .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [65536];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t rd_q[$], wr_q[$], exp_rd[$], exp_wr[$];
  int  act_cnt, act_first, act_last, both_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  // system bus: data for a read appears the clock after the strobe, garbage otherwise
  always @(posedge clk) ext_data <= ext_read ? mem[ext_adr] : 8'($urandom);

  always @(negedge clk) begin
    if (ext_read)  rd_q.push_back('{cyc, ext_adr, 8'h00});
    if (oam_write) wr_q.push_back('{cyc, {8'h00, oam_adr}, oam_dout});
    if (ext_read && oam_write) both_cnt++;
    if (dma_active) begin
      act_cnt++;
      if (act_first < 0) act_first = cyc;
      act_last = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] eff(input logic [7:0] v);
    return (v >= 8'hE0) ? v - 8'h20 : v;
  endfunction

  task automatic clear_mon();
    rd_q.delete(); wr_q.delete(); exp_rd.delete(); exp_wr.delete();
    act_cnt = 0; act_first = -1; act_last = -1; both_cnt = 0;
  endtask

  // called #1 after a posedge; returns the commit clock (the edge sampling the released strobe)
  task automatic do_write(input logic [7:0] v, output int c);
    reg_din   = v;
    reg_write = 1'b1;
    @(posedge clk); #1;
    reg_write = 1'b0;
    @(posedge clk); #1;
    c = cyc;
  endtask

  // expected events of one transfer starting at clock s, truncated before clock upto
  task automatic model_xfer(input int s, input logic [7:0] pg, input int upto);
    for (int i = 0; i < LEN; i++) begin
      if (s + 4*i < upto)     exp_rd.push_back('{s + 4*i, {pg, 8'(i)}, 8'h00});
      if (s + 4*i + 2 < upto) exp_wr.push_back('{s + 4*i + 2, {8'h00, 8'(i)}, mem[{pg, 8'(i)}]});
    end
  endtask

  task automatic cmp_events(input string tag);
    int bad;
    chk({tag, "/nrd"}, rd_q.size(), exp_rd.size());
    chk({tag, "/nwr"}, wr_q.size(), exp_wr.size());
    bad = 0;
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
      if (rd_q[i].cyc != exp_rd[i].cyc || rd_q[i].adr !== exp_rd[i].adr) bad++;
    chk({tag, "/rd_bad"}, bad, 0);
    bad = 0;
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
      if (wr_q[i].cyc != exp_wr[i].cyc || wr_q[i].adr !== exp_wr[i].adr ||
          wr_q[i].dat !== exp_wr[i].dat) bad++;
    chk({tag, "/wr_bad"}, bad, 0);
    if (rd_q.size() > 0 && exp_rd.size() > 0) begin
      chk({tag, "/rd0_cyc"}, rd_q[0].cyc, exp_rd[0].cyc);
      chk({tag, "/rd0_adr"}, rd_q[0].adr, exp_rd[0].adr);
    end
    chk({tag, "/both"}, both_cnt, 0);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (act_first >= 0 && !dma_active) ok = 1'b1;
    end
    chk({tag, "/idle"}, ok, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_read(input logic [15:0] a, input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (ext_read && ext_adr == a) ok = 1'b1;
    end
    chk({tag, "/reach"}, ok, 1'b1);
  endtask

  task automatic run_single(input logic [7:0] v, input string tag);
    int c;
    clear_mon();
    do_write(v, c);
    chk({tag, "/dout"}, reg_dout, v);
    model_xfer(c + SD, eff(v), BIG);
    wait_idle(tag);
    cmp_events(tag);
    chk({tag, "/act_cnt"}, act_cnt, 640);
    chk({tag, "/act_first"}, act_first, c + SD);
    chk({tag, "/act_last"}, act_last, c + SD + 639);
  endtask

  initial begin
    int c1, c2;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    reset = 1'b1; reg_write = 1'b0; reg_din = 8'h00;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst/active", dma_active, 1'b0);
    chk("rst/dout", reg_dout, 8'h00);
    chk("rst/strobes", {ext_read, oam_write}, 2'b00);
    chk("rst/ext_adr", ext_adr, 16'h0000);
    chk("rst/oam", {oam_adr, oam_dout}, 16'h0000);
    reset = 1'b0;
    @(posedge clk); #1;

    run_single(8'hC1, "c1");
    run_single(8'hFE, "fe");
    run_single(8'hDF, "df");
    for (int r = 0; r < 3; r++) run_single(8'($urandom), "rnd");

    // restart mid-transfer at byte 50
    clear_mon();
    do_write(8'h80, c1);
    wait_read(16'h8032, "rs");
    @(posedge clk); #1;
    do_write(8'hC0, c2);
    model_xfer(c1 + SD, 8'h80, c2 + SD);
    model_xfer(c2 + SD, 8'hC0, BIG);
    wait_idle("rs");
    cmp_events("rs");
    chk("rs/act_cnt", act_cnt, c2 + SD + 640 - (c1 + SD));
    chk("rs/no_gap", act_last - act_first + 1, act_cnt);
    chk("rs/act_last", act_last, c2 + SD + 639);

    // two writes before the start: only the second one runs
    clear_mon();
    do_write(8'h80, c1);
    do_write(8'h90, c2);
    model_xfer(c2 + SD, 8'h90, BIG);
    wait_idle("dbl");
    cmp_events("dbl");
    chk("dbl/act_cnt", act_cnt, 640);

    // readback during and after a transfer
    clear_mon();
    do_write(8'h5A, c1);
    chk("rd/commit", reg_dout, 8'h5A);
    repeat (100) @(posedge clk);
    #1;
    chk("rd/busy", dma_active, 1'b1);
    chk("rd/during", reg_dout, 8'h5A);
    wait_idle("rd");
    chk("rd/after", reg_dout, 8'h5A);

    // reset at byte 100 aborts immediately
    clear_mon();
    do_write(8'h80, c1);
    wait_read(16'h8064, "rst100");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst100/active", dma_active, 1'b0);
    chk("rst100/strobes", {ext_read, oam_write}, 2'b00);
    chk("rst100/dout", reg_dout, 8'h00);
    chk("rst100/ext_adr", ext_adr, 16'h0000);
    reset = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("rst100/nwr", wr_q.size(), 100);
    chk("rst100/idle", dma_active, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
